// File: rtl/dual_thread_fetch_buffer_pkg.sv
// Shared types and constants for the dual-thread fetch buffer.
package dual_thread_fetch_buffer_pkg;

   localparam int unsigned InstWidth = 32;
   localparam int unsigned TidWidth  = 1;
   localparam logic [31:0] PcIncr    = 32'd4;

   typedef logic [TidWidth-1:0] tid_t;

   // One queued fetch: the PC it was fetched from and the returned word.
   typedef struct packed {
      logic [31:0]          pc;
      logic [InstWidth-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/dual_thread_fetch_buffer_fetch_queue.sv
// Per-thread instruction FIFO with push, pop, flush and occupancy count.
// Flush wins over a push or pop in the same cycle. Head reads as zero when empty.
module dual_thread_fetch_buffer_fetch_queue
   import dual_thread_fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fq_entry_t                  push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     cnt,
   output fq_entry_t                  head
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   fq_entry_t             mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q;
   logic [PtrW-1:0]       rd_ptr_q;
   logic [CntW-1:0]       cnt_q;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (pop && !push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Head presentation, masked to zero while empty.
   always_comb begin
      cnt  = cnt_q;
      head = '0;
      if (cnt_q != '0) begin
         head = mem_q[rd_ptr_q];
      end
   end

endmodule

// File: rtl/dual_thread_fetch_buffer.sv
// Two-thread fetch stage: per-thread PC and queue, round-robin sharing of one
// synchronous instruction-memory port, and head-of-queue presentation to decode.
// Optional build macro FETCH_PERF_CNT_EN adds saturating starve0/starve1 counters.
module dual_thread_fetch_buffer
   import dual_thread_fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC0 = 32'h0000_0000,
   parameter logic [31:0] RESET_PC1 = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        dt,
   input  logic        br_vld,
   input  logic        br_thread,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        fasmds0,
   output logic        fasmds1,
   output logic [31:0] d_inst,
   output logic [31:0] d_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] starve0,
   output logic [15:0] starve1
`endif
);

   localparam int unsigned CntW  = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

   logic [31:0]     pc0_q, pc1_q;
   logic            rr_q;
   logic            rsp_vld_q;
   tid_t            rsp_thread_q;
   logic [31:0]     rsp_pc_q;

   logic [CntW-1:0] cnt0, cnt1;
   fq_entry_t       head0, head1;
   fq_entry_t       push_entry;

   logic            redir, redir0, redir1;
   logic            inflight0, inflight1;
   logic            elig0, elig1;
   logic            gnt_vld, gnt_thread;
   logic            push_ok, push0, push1;
   logic            pop0, pop1;
   logic            unused_tgt;

   // Redirect, credit and push/pop qualification.
   always_comb begin
      redir     = en & br_vld;
      redir0    = redir & ~br_thread;
      redir1    = redir & br_thread;
      inflight0 = rsp_vld_q & (rsp_thread_q == 1'b0);
      inflight1 = rsp_vld_q & (rsp_thread_q == 1'b1);
      // A thread being redirected never requests in the same cycle.
      elig0     = en & ((cnt0 + CntW'(inflight0)) < DepthC) & ~(br_vld & ~br_thread);
      elig1     = en & ((cnt1 + CntW'(inflight1)) < DepthC) & ~(br_vld & br_thread);
      // A redirect kills the response of its own thread that lands this cycle.
      push_ok   = rsp_vld_q & ~(redir & (br_thread == rsp_thread_q));
      push0     = push_ok & (rsp_thread_q == 1'b0);
      push1     = push_ok & (rsp_thread_q == 1'b1);
      pop0      = en & ~dt & fasmds0;
      pop1      = en & dt & fasmds1;
   end

   // Round-robin grant of the memory port; held off while in reset.
   always_comb begin
      gnt_vld    = 1'b0;
      gnt_thread = 1'b0;
      if (rst_n) begin
         if (elig0 && elig1) begin
            gnt_vld    = 1'b1;
            gnt_thread = rr_q;
         end else if (elig0) begin
            gnt_vld    = 1'b1;
            gnt_thread = 1'b0;
         end else if (elig1) begin
            gnt_vld    = 1'b1;
            gnt_thread = 1'b1;
         end
      end
      imem_req  = gnt_vld;
      imem_addr = '0;
      if (gnt_vld) begin
         imem_addr = gnt_thread ? pc1_q : pc0_q;
      end
   end

   // Program counters and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc0_q <= RESET_PC0;
         pc1_q <= RESET_PC1;
         rr_q  <= 1'b0;
      end else begin
         if (gnt_vld) begin
            rr_q <= ~gnt_thread;
         end
         if (redir0) begin
            pc0_q <= {br_target[31:2], 2'b00};
         end else if (gnt_vld && !gnt_thread) begin
            pc0_q <= pc0_q + PcIncr;
         end
         if (redir1) begin
            pc1_q <= {br_target[31:2], 2'b00};
         end else if (gnt_vld && gnt_thread) begin
            pc1_q <= pc1_q + PcIncr;
         end
      end
   end

   // Outstanding-request tracking for the one-cycle memory latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_vld_q    <= 1'b0;
         rsp_thread_q <= '0;
         rsp_pc_q     <= '0;
      end else begin
         rsp_vld_q <= gnt_vld;
         if (gnt_vld) begin
            rsp_thread_q <= gnt_thread;
            rsp_pc_q     <= imem_addr;
         end
      end
   end

   assign push_entry = '{pc: rsp_pc_q, inst: imem_rdata};
   assign unused_tgt = ^br_target[1:0];

   dual_thread_fetch_buffer_fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push0),
      .push_data (push_entry),
      .pop       (pop0),
      .flush     (redir0),
      .cnt       (cnt0),
      .head      (head0)
   );

   dual_thread_fetch_buffer_fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push1),
      .push_data (push_entry),
      .pop       (pop1),
      .flush     (redir1),
      .cnt       (cnt1),
      .head      (head1)
   );

   // Decode-facing outputs: availability flags and head of the selected queue.
   always_comb begin
      fasmds0 = (cnt0 != '0);
      fasmds1 = (cnt1 != '0);
      d_inst  = dt ? head1.inst : head0.inst;
      d_pc    = dt ? head1.pc   : head0.pc;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] starve0_q, starve1_q;

   // Saturating count of enabled cycles spent with an empty, unredirected queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve0_q <= '0;
         starve1_q <= '0;
      end else begin
         if (en && (cnt0 == '0) && !(br_vld && !br_thread) && (starve0_q != 16'hFFFF)) begin
            starve0_q <= starve0_q + 16'd1;
         end
         if (en && (cnt1 == '0) && !(br_vld && br_thread) && (starve1_q != 16'hFFFF)) begin
            starve1_q <= starve1_q + 16'd1;
         end
      end
   end

   assign starve0 = starve0_q;
   assign starve1 = starve1_q;
`endif

endmodule

// File: tb/tb_dual_thread_fetch_buffer.sv
// Randomized bench for dual_thread_fetch_buffer against a queue-based reference model.
module tb_dual_thread_fetch_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n, en, dt, br_vld, br_thread;
   logic [31:0] br_target, imem_addr, imem_rdata, d_inst, d_pc;
   logic        imem_req, fasmds0, fasmds1;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] starve0, starve1;
`endif

   always #5 clk = ~clk;

   dual_thread_fetch_buffer #(
      .DEPTH     (DEPTH),
      .RESET_PC0 (32'h0000_0000),
      .RESET_PC1 (32'h0000_1000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .dt         (dt),
      .br_vld     (br_vld),
      .br_thread  (br_thread),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .fasmds0    (fasmds0),
      .fasmds1    (fasmds1),
      .d_inst     (d_inst),
      .d_pc       (d_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .starve0    (starve0),
      .starve1    (starve1)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference state: queues hold {pc, inst}.
   logic [63:0] mq0[$];
   logic [63:0] mq1[$];
   logic [31:0] m_pc0, m_pc1, m_pa;
   bit          m_rr, m_pv, m_pt;
   int          m_st0, m_st1;
   bit          last_req;
   logic [31:0] last_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
   endfunction

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      m_pc0 = 32'h0000_0000;
      m_pc1 = 32'h0000_1000;
      m_rr  = 1'b0;
      m_pv  = 1'b0;
      m_pt  = 1'b0;
      m_pa  = '0;
      m_st0 = 0;
      m_st1 = 0;
   endtask

   // One clock: drive inputs mid-cycle, compare against the model, advance the model.
   task automatic cycle(input bit r, input bit e, input bit d, input bit bv, input bit bt,
                        input logic [31:0] tgt);
      int          s0, s1;
      bit          el0, el1, g, gt, redir;
      logic [31:0] exp_addr;
      logic [63:0] hd;
      @(negedge clk);
      rst_n      = r;
      en         = e;
      dt         = d;
      br_vld     = bv;
      br_thread  = bt;
      br_target  = tgt;
      imem_rdata = last_req ? mem_word(last_addr) : $urandom();
      #1;
      if (!r) model_reset();
      s0  = mq0.size();
      s1  = mq1.size();
      el0 = r && e && (s0 + int'(m_pv && !m_pt) < DEPTH) && !(bv && !bt);
      el1 = r && e && (s1 + int'(m_pv && m_pt) < DEPTH) && !(bv && bt);
      g   = el0 || el1;
      gt  = (el0 && el1) ? m_rr : el1;
      exp_addr = g ? (gt ? m_pc1 : m_pc0) : 32'h0;
      hd = 64'h0;
      if (d && s1 > 0) hd = mq1[0];
      if (!d && s0 > 0) hd = mq0[0];
      check("imem_req", {31'h0, imem_req}, {31'h0, g});
      check("imem_addr", imem_addr, exp_addr);
      check("fasmds0", {31'h0, fasmds0}, {31'h0, s0 != 0});
      check("fasmds1", {31'h0, fasmds1}, {31'h0, s1 != 0});
      check("d_inst", d_inst, hd[31:0]);
      check("d_pc", d_pc, hd[63:32]);
`ifdef FETCH_PERF_CNT_EN
      check("starve0", {16'h0, starve0}, m_st0);
      check("starve1", {16'h0, starve1}, m_st1);
`endif
      last_req  = imem_req;
      last_addr = imem_addr;
      if (r) begin
         redir = e && bv;
         if (e && s0 == 0 && !(bv && !bt) && m_st0 < 65535) m_st0++;
         if (e && s1 == 0 && !(bv && bt) && m_st1 < 65535) m_st1++;
         if (e && !d && s0 > 0) void'(mq0.pop_front());
         if (e && d && s1 > 0) void'(mq1.pop_front());
         if (m_pv && !(redir && bt == m_pt)) begin
            if (m_pt) mq1.push_back({m_pa, mem_word(m_pa)});
            else      mq0.push_back({m_pa, mem_word(m_pa)});
         end
         if (redir) begin
            if (bt) begin
               mq1.delete();
               m_pc1 = tgt & 32'hFFFF_FFFC;
            end else begin
               mq0.delete();
               m_pc0 = tgt & 32'hFFFF_FFFC;
            end
         end
         m_pv = g;
         m_pt = gt;
         m_pa = exp_addr;
         if (g) begin
            if (gt) m_pc1 = m_pc1 + 32'd4;
            else    m_pc0 = m_pc0 + 32'd4;
            m_rr = !gt;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; dt = 1'b0; br_vld = 1'b0; br_thread = 1'b0;
      br_target = '0; imem_rdata = '0;
      last_req = 1'b0; last_addr = '0;
      model_reset();

      // Reset held: everything quiet.
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);

      // Release: requests alternate between threads, flags rise in cycles 2 and 3.
      cycle(1, 1, 0, 0, 0, 0);
      check("seq_c0_addr", imem_addr, 32'h0000_0000);
      cycle(1, 1, 0, 0, 0, 0);
      check("seq_c1_addr", imem_addr, 32'h0000_1000);
      cycle(1, 1, 0, 0, 0, 0);
      check("seq_c2_addr", imem_addr, 32'h0000_0004);
      check("seq_c2_f0", {31'h0, fasmds0}, 32'h1);
      cycle(1, 1, 0, 0, 0, 0);
      check("seq_c3_addr", imem_addr, 32'h0000_1004);
      check("seq_c3_f1", {31'h0, fasmds1}, 32'h1);

      // dt held at 0: queue 1 fills, then only thread 0 is fetched.
      for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 0);
      check("q1_full_req_t0", {31'h0, imem_req && imem_addr < 32'h1000}, 32'h1);

      // Redirect thread 0 while its response is pending.
      cycle(1, 1, 0, 1, 0, 32'h0000_2003);
      cycle(1, 1, 0, 0, 0, 0);
      check("redir_f0_clear", {31'h0, fasmds0}, 32'h0);
      check("redir_addr", imem_addr, 32'h0000_2000);
      check("redir_q1_kept", {31'h0, fasmds1}, 32'h1);

      // Stall with a response in flight and a redirect that must be ignored.
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, i[0], $urandom());
      cycle(1, 1, 1, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(1, $urandom_range(0, 9) < 8, 1'($urandom()), $urandom_range(0, 15) == 0,
               1'($urandom()), $urandom());
      end

      // Mid-operation reset then more traffic.
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         cycle(1, $urandom_range(0, 9) < 9, 1'($urandom()), $urandom_range(0, 31) == 0,
               1'($urandom()), $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dual_thread_fetch_buffer.md
Name: dual_thread_fetch_buffer

Overview:
- Fetch stage feeding the two-thread selector. Keeps one PC and one instruction queue per thread, arbitrates a single synchronous instruction-memory port between the threads, and drives per-thread "instruction available" flags fasmds0/fasmds1.
- Pops the head of the thread the selector chose (dt) and presents its instruction and PC to decode.

Parameters:
- DEPTH, 4, entries per thread queue; power of two, minimum 2.
- RESET_PC0, 32'h0000_0000, thread-0 PC after reset.
- RESET_PC1, 32'h0000_1000, thread-1 PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance enable.
- dt  in  1  thread selected at decode this cycle, from the selector.
- br_vld  in  1  redirect request.
- br_thread  in  1  thread being redirected.
- br_target  in  32  redirect byte address.
- imem_req  out  1  instruction-memory read strobe.
- imem_addr  out  32  read address, word aligned.
- imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
- fasmds0  out  1  thread-0 queue non-empty.
- fasmds1  out  1  thread-1 queue non-empty.
- d_inst  out  32  head instruction of queue dt.
- d_pc  out  32  PC of that instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc0=RESET_PC0, pc1=RESET_PC1.
  - Both queues empty; fasmds0=fasmds1=0.
  - Round-robin pointer rr=0; response-valid and kill flags cleared.
  - imem_req=0, imem_addr=0, d_inst=0, d_pc=0.
- Credit:
  - eligN = en & ((cntN + inflightN) < DEPTH) & ~(br_vld & br_thread==N).
  - inflightN is 1 while an uncommitted response for thread N is pending.
- Arbitration (combinational):
  - One eligible thread: grant it.
  - Both eligible: grant thread rr.
  - rr <= ~granted thread on every grant.
  - imem_req=1 when any thread is granted; imem_addr=pc of the granted thread.
  - pc of the granted thread += 4 at the clock edge (32-bit wrap).
- Response:
  - Registered rsp_vld/rsp_thread/rsp_pc.
  - Next cycle, imem_rdata and rsp_pc are pushed into queue rsp_thread unless killed.
  - The push ignores en; an in-flight word is never lost while stalled.
- Pop:
  - pop = en & (dt ? fasmds1 : fasmds0).
  - Removes the head of queue dt.
  - dt pointing at an empty queue: no pop, no error.
- Push and pop on the same queue in the same cycle: both occur, count unchanged.
- The credit rule prevents overflow: a push never hits a full queue.
- Outputs:
  - fasmds0 = cnt0!=0; fasmds1 = cnt1!=0.
  - d_inst/d_pc are combinational head of queue dt; 0 when that queue is empty.
- Redirect (br_vld & en):
  - Empties queue br_thread.
  - pc[br_thread] <= {br_target[31:2],2'b00}.
  - Kills any pending response for that thread, whether issued last cycle or this cycle.
  - The redirected thread is ineligible this cycle; its first new request is next cycle.
  - Overrides a pop or a push of the same thread in the same cycle.
  - The other thread is untouched.
- en=0:
  - No new requests, no pops, no PC or rr change.
  - Redirect is ignored.
  - A pending response still commits.
- Reset mid-operation: all state returns to reset values at once; a late imem_rdata is discarded because rsp_vld is cleared.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs starve0 and starve1, each 16 bits.
  - Each increments (saturating at 16'hFFFF) on every en cycle where its queue is empty and the thread is not being redirected.
  - Both reset to 0.
- When undefined, the ports and counters do not exist.

Decomposition:
- Shared package holds:
  - Typedef for a queue entry {pc[31:0], inst[31:0]}.
  - Constants for instruction width (32) and PC increment (4).
  - Thread-ID width (1).
- One natural sub-module, fetch_queue: a DEPTH-entry FIFO with push, pop, flush and count, instantiated once per thread.

Test Plan:
- Reset release with en=1 and imem returning addr-as-data:
  - Requests alternate 0x0, 0x1000, 0x4, 0x1004.
  - fasmds0 rises in cycle 2; fasmds1 rises in cycle 3.
- dt held at 0, no pops on thread 1:
  - Queue 1 fills to 4.
  - Then every request goes to thread 0, and imem_req never goes to thread 1 while its cnt+inflight=4.
- Redirect thread 0 to 0x0000_2003 while a thread-0 response is pending:
  - That response is dropped; fasmds0=0 next cycle.
  - Next thread-0 request address is 0x2000.
  - Thread-1 contents are unchanged.
- en=0 for 3 cycles with one response pending:
  - Entry still lands in its queue; no imem_req; pc values frozen.
  - Redirect asserted during the stall has no effect.
- Simultaneous push and pop on a queue holding 2 entries:
  - cnt stays 2; d_inst advances to the next entry in order.
- FETCH_PERF_CNT_EN build with thread 1 never fetched (queue 1 kept full, then drained and held empty):
  - starve1 counts each en cycle while empty and saturates at 16'hFFFF.
